fb_bank_scheduler: RTL and testbench

Ping-pong bank controller for the camera framebuffer. Sits between the camera pixel stream (12-bit pixels with a frame-end pulse) and two framebuffer BRAM banks. It writes each incoming frame into the back bank and hands a completed frame to the display side by swapping banks at the display's vsync. This guarantees the display never reads a partially written frame.

---
 rtl/fb_bank_scheduler.sv | 166 ++++++++++++++++
 tb/tb_fb_bank_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fb_bank_scheduler.sv
// fb_bank_scheduler: ping-pong framebuffer bank controller.
// Camera pixels are written into the back bank. The banks swap only at a display
// vsync, and only once the back bank holds a complete frame.
// Optional feature macro: FB_DROP_COUNT_EN, which adds a saturating counter of
// discarded frames on drop_count. When the macro is undefined, drop_count is tied to 0.
//
// state | meaning
// ------+----------------------------------------------------------------
// SYNC  | waiting for a frame boundary; all pixels discarded
// FILL  | writing the current camera frame into bank wr_bank
// READY | back bank holds a complete frame, waiting for display vsync
module fb_bank_scheduler #(
    parameter int FRAME_WIDTH  = 240,
    parameter int FRAME_HEIGHT = 320,
    parameter int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT,
    parameter int ADDR_W       = $clog2(FRAME_PIXELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [11:0]       axiid,
    input  logic              frame_done,
    input  logic              rd_vsync,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              rd_bank,
    output logic              swap,
    output logic              frame_err,
    output logic [15:0]       drop_count
);

    // The counter must be able to hold FRAME_PIXELS itself, because it saturates there.
    localparam int                CNT_W   = $clog2(FRAME_PIXELS + 1);
    localparam logic [CNT_W-1:0]  PIX_MAX = CNT_W'(FRAME_PIXELS);

    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              long_q, long_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              wr_bank_q;
    logic              swap_q, swap_d;
    logic              err_q, err_d;

    // Next-state, pixel acceptance and frame-end decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        long_d    = long_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        swap_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (frame_done) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    long_d  = 1'b0;
                end
            end
            S_FILL: begin
                if (axiiv) begin
                    if (cnt_q < PIX_MAX) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[ADDR_W-1:0];
                        wr_data_d = axiid;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end else begin
                        long_d = 1'b1;
                    end
                end
                // A pixel that arrives with frame_done is already counted in cnt_d and long_d.
                if (frame_done) begin
                    err_d = (cnt_d != PIX_MAX) || long_d;
                    if (rd_vsync) begin
                        swap_d = 1'b1;
                        cnt_d  = '0;
                        long_d = 1'b0;
                    end else begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (rd_vsync) begin
                    swap_d = 1'b1;
                    if (frame_done) begin
                        state_d = S_FILL;
                        cnt_d   = '0;
                        long_d  = 1'b0;
                    end else begin
                        state_d = S_SYNC;
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    // State, counter, registered write port and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_SYNC;
            cnt_q     <= '0;
            long_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_bank_q <= 1'b0;
            swap_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            long_q    <= long_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            swap_q    <= swap_d;
            err_q     <= err_d;
            if (swap_d) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_bank   = wr_bank_q;
    // The display always reads the bank that is not being written.
    assign rd_bank   = ~wr_bank_q;
    assign swap      = swap_q;
    assign frame_err = err_q;

`ifdef FB_DROP_COUNT_EN
    logic [15:0] drop_q;
    logic        drop_inc;

    // A frame is dropped when the camera finishes one while the back bank is still full.
    assign drop_inc = (state_q == S_READY) && frame_done && !rd_vsync;

    // Saturating count of dropped frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 16'd0;
        end else if (drop_inc && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_fb_bank_scheduler.sv
// Directed testbench for fb_bank_scheduler, built with FRAME_PIXELS = 8.
module tb_fb_bank_scheduler;

    localparam int ADDR_W = 3;
`ifdef FB_DROP_COUNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              axiiv = 1'b0;
    logic [11:0]       axiid = 12'd0;
    logic              frame_done = 1'b0;
    logic              rd_vsync = 1'b0;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              rd_bank;
    logic              swap;
    logic              frame_err;
    logic [15:0]       drop_count;

    int checks = 0;
    int errors = 0;

    fb_bank_scheduler #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2)) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .frame_done(frame_done), .rd_vsync(rd_vsync),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_bank(rd_bank), .swap(swap), .frame_err(frame_err), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [11:0] d;
        logic        fd;
        logic        vs;
        logic        en;
        logic        care;
        logic [2:0]  addr;
        logic [11:0] dat;
        logic        wb;
        logic        sw;
        logic        err;
        logic [15:0] drop;
    } vec_t;

    vec_t vq[$];

    function automatic int dexp(int n);
        return DROP_EN ? n : 0;
    endfunction

    function automatic void add(int v, int d, int fd, int vs, int en, int care,
                                int addr, int dat, int wb, int sw, int err, int drop);
        vec_t t;
        t.v = v[0]; t.d = d[11:0]; t.fd = fd[0]; t.vs = vs[0];
        t.en = en[0]; t.care = care[0]; t.addr = addr[2:0]; t.dat = dat[11:0];
        t.wb = wb[0]; t.sw = sw[0]; t.err = err[0]; t.drop = drop[15:0];
        vq.push_back(t);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and sample the outputs 1 ns after the rising edge.
    task automatic step(logic v, logic [11:0] d, logic fd, logic vs);
        axiiv = v; axiid = d; frame_done = fd; rd_vsync = vs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Frame that arrives in SYNC: discarded.
        for (int i = 0; i < 8; i++) add(1, 12'h001 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0, dexp(0));
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, dexp(0));
        // Full frame into bank 0, frame_done on the last pixel.
        for (int i = 0; i < 8; i++)
            add(1, 12'h101 + i, (i == 7) ? 1 : 0, 0, 1, 1, i, 12'h101 + i, 0, 0, 0, dexp(0));
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dexp(0));
        // READY + vsync: swap into SYNC.
        add(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, dexp(0));
        for (int i = 0; i < 3; i++) add(1, 12'h201 + i, 0, 0, 0, 0, 0, 0, 1, 0, 0, dexp(0));
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, dexp(0));
        // Long frame into bank 1: 10 pixels, only 8 written, frame_err raised.
        for (int i = 0; i < 10; i++)
            add(1, 12'h301 + i, 0, 0, (i < 8) ? 1 : 0, (i < 8) ? 1 : 0, i, 12'h301 + i, 1, 0, 0, dexp(0));
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, dexp(0));
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, dexp(0));
        // READY: two frame_done pulses are dropped frames, and the pixel is discarded.
        add(1, 12'h3FF, 1, 0, 0, 0, 0, 0, 1, 0, 0, dexp(1));
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, dexp(2));
        // READY: frame_done together with vsync gives swap -> FILL, with no drop counted.
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, dexp(2));
        add(1, 12'h401, 0, 0, 1, 1, 0, 12'h401, 0, 0, 0, dexp(2));
        for (int i = 1; i < 5; i++)
            add(1, 12'h401 + i, 0, 0, 1, 1, i, 12'h401 + i, 0, 0, 0, dexp(2));
        // FILL: 5-pixel frame ends together with vsync -> frame_err, swap, stay in FILL.
        add(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 1, dexp(2));
        add(1, 12'h501, 0, 0, 1, 1, 0, 12'h501, 1, 0, 0, dexp(2));
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, dexp(2));
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, dexp(2));
        // vsync in SYNC is ignored.
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, dexp(2));
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, dexp(2));
        for (int i = 0; i < 8; i++)
            add(1, 12'h601 + i, (i == 7) ? 1 : 0, 0, 1, 1, i, 12'h601 + i, 0, 0, 0, dexp(2));
        add(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, dexp(2));
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, dexp(2));
        for (int i = 0; i < 6; i++)
            add(1, 12'h701 + i, 0, 0, 1, 1, i, 12'h701 + i, 1, 0, 0, dexp(2));

        // Reset values.
        #1;
        chk("rst wr_en", 32'(wr_en), 0);
        chk("rst wr_addr", 32'(wr_addr), 0);
        chk("rst wr_data", 32'(wr_data), 0);
        chk("rst wr_bank", 32'(wr_bank), 0);
        chk("rst rd_bank", 32'(rd_bank), 1);
        chk("rst swap", 32'(swap), 0);
        chk("rst frame_err", 32'(frame_err), 0);
        chk("rst drop_count", 32'(drop_count), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].v, vq[i].d, vq[i].fd, vq[i].vs);
            chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vq[i].en));
            if (vq[i].care) begin
                chk($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vq[i].addr));
                chk($sformatf("vec%0d wr_data", i), 32'(wr_data), 32'(vq[i].dat));
            end
            chk($sformatf("vec%0d wr_bank", i), 32'(wr_bank), 32'(vq[i].wb));
            chk($sformatf("vec%0d rd_bank", i), 32'(rd_bank), 32'(!vq[i].wb));
            chk($sformatf("vec%0d swap", i), 32'(swap), 32'(vq[i].sw));
            chk($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vq[i].err));
            chk($sformatf("vec%0d drop_count", i), 32'(drop_count), 32'(vq[i].drop));
        end

        // Asynchronous reset while FILL is at address 5 on bank 1.
        #2;
        rst = 1'b0;
        #1;
        chk("midrst wr_en", 32'(wr_en), 0);
        chk("midrst wr_bank", 32'(wr_bank), 0);
        chk("midrst rd_bank", 32'(rd_bank), 1);
        chk("midrst wr_addr", 32'(wr_addr), 0);
        chk("midrst drop_count", 32'(drop_count), 0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 12'h801, 1'b0, 1'b0);
        chk("postrst discard wr_en", 32'(wr_en), 0);
        step(1'b1, 12'h802, 1'b0, 1'b0);
        chk("postrst discard2 wr_en", 32'(wr_en), 0);
        step(1'b0, 12'h000, 1'b1, 1'b0);
        chk("postrst sync fd wr_en", 32'(wr_en), 0);
        step(1'b1, 12'h803, 1'b0, 1'b0);
        chk("postrst write wr_en", 32'(wr_en), 1);
        chk("postrst write wr_addr", 32'(wr_addr), 0);
        chk("postrst write wr_data", 32'(wr_data), 32'h803);
        chk("postrst write wr_bank", 32'(wr_bank), 0);
        step(1'b0, 12'h000, 1'b0, 1'b0);
        chk("postrst idle wr_en", 32'(wr_en), 0);
        chk("postrst hold wr_data", 32'(wr_data), 32'h803);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
